bcd_scan_ctrl: RTL and testbench
================================

# bcd_scan_ctrl

Sequencing and display-sharing controller for the 3-digit BCD counter path. It holds a 12-bit packed BCD value and advances it by +1 on a prescaled run tick or a manual step. It drives one shared hex-to-7-segment decoder with a time-multiplexed digit and active-low digit enables, which replaces three parallel decoders. It sits between the board switches/buttons and the single segment bus of the display.

## Interface
- TICK_DIV, default 100_000_000: clk cycles per automatic increment while running; legal range ≥ 2.
- SCAN_DIV, default 100_000: clk cycles each digit stays selected; legal range ≥ 2.
- BLANK_LZ, default 1: 1 blanks leading zeros in the hundreds and tens digits.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 enables automatic increments.
- step  in  1  single-cycle pulse; requests one increment.
- load  in  1  single-cycle pulse; loads load_val.
- load_val  in  12  packed BCD {hundreds, tens, ones}.
- bcd_val  out  12  current packed BCD count.
- wrap  out  1  one-cycle pulse when the count rolls over 999→000.
- digit_hex  out  4  BCD digit for the shared decoder.
- an  out  3  active-low digit enables: an[0]=ones, an[1]=tens, an[2]=hundreds.
- dp  out  1  active-low decimal point.

## Operation
- Prescaler `presc` (0..TICK_DIV-1):
  - Increments each cycle while run=1 and holds its value while run=0.
  - Wraps from TICK_DIV-1 to 0.
  - Is cleared to 0 by load.
- Increment request: `inc = step | (run & presc==TICK_DIV-1)`. A step and a terminal count in the same cycle produce exactly one increment.
- Priority per cycle: reset > load > inc.
- Load: each load_val digit > 9 is stored as 0; valid digits are stored unchanged. bcd_val therefore never holds a digit > 9.
- BCD increment with per-digit carry:
  - ones 9→0 carries into tens; tens 9→0 carries into hundreds.
  - 999→000 asserts wrap for exactly one cycle.
  - Any other result leaves wrap=0.
- Scan counter `scnt` (0..SCAN_DIV-1): runs continuously. At SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→2→0. Index 3 is unreachable; if it ever occurs, it recovers to 0 on the next edge.
- Display outputs are registered from the digit index and bcd_val:
  - digit_hex = selected digit.
  - an = one-hot low for the index.
- Blanking with BLANK_LZ=1 (an forced to 3'b111 while digit_hex keeps its value):
  - Index 2 is blanked when hundreds=0.
  - Index 1 is blanked when hundreds=0 and tens=0.
  - The ones digit is never blanked.
- dp = 0 only when index=0 and run=0 (paused indicator); otherwise 1.

## Timing
- Reset values: bcd_val=12'h000, wrap=0, presc=0, scnt=0, index=0, digit_hex=4'h0, an=3'b110, dp=1.
- Step latency: step high in cycle N → bcd_val updated at edge N+1 → digit_hex reflects the new value at edge N+2 if that digit is selected.
- Run latency: the increment lands on the edge after the cycle in which presc=TICK_DIV-1. With run held high, increments occur exactly every TICK_DIV cycles.
- wrap is registered and rises on the same edge that bcd_val becomes 000.
- Load latency: load in cycle N → bcd_val=load_val (sanitised) at edge N+1. A step in the same cycle is dropped.
- run deasserted mid-count: presc freezes; re-asserting run resumes from the frozen count with no lost or extra increments.
- Reset asserted mid-operation: all state returns to reset values at the next edge, including during a wrap or load.
- Each digit is selected for exactly SCAN_DIV cycles; a full frame is 3·SCAN_DIV cycles.

## Test plan
- Reset, then 3 step pulses 4 cycles apart → bcd_val 001, 002, 003, each one cycle after its pulse; wrap stays 0.
- load_val=12'h099, load, then step → bcd_val=12'h100 (double carry); wrap=0.
- load_val=12'h999, load, then step → bcd_val=12'h000 with wrap=1 for exactly one cycle.
- TICK_DIV=4, run=1 for 20 cycles → 5 increments exactly 4 cycles apart. Drop run for 7 cycles, then re-raise → next increment arrives after the remaining count.
- load_val=12'h1AF, load → bcd_val=12'h100. Same-cycle load with load_val=12'h050 plus step → bcd_val=12'h050.
- SCAN_DIV=3, BLANK_LZ=1, bcd_val=12'h007 → an cycles 110, 111, 111 every 3 cycles; digit_hex=7 during the ones slot; dp=0 on the ones slot only while run=0.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: 3-digit packed-BCD up-counter with a prescaled run tick, a
// manual step and a load, driving one shared 7-segment decoder through a
// time-multiplexed digit and active-low digit enables.
module bcd_scan_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic [11:0] bcd_val,
    output logic        wrap,
    output logic [3:0]  digit_hex,
    output logic [2:0]  an,
    output logic        dp
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_r;
    logic [SW-1:0] scnt_r;
    logic [1:0]    idx_r;
    logic [11:0]   bcd_r;
    logic          wrap_r;
    logic [3:0]    digit_hex_r;
    logic [2:0]    an_r;
    logic          dp_r;

    logic          inc_s;
    logic [1:0]    idx_nxt_s;
    logic [3:0]    sel_digit_s;
    logic          blank_s;
    logic [2:0]    an_nxt_s;

    // Out-of-range digits are replaced by zero so the count stays valid BCD.
    function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    // Packed-BCD +1 with per-digit carry; bit 12 flags the 999 -> 000 rollover.
    function automatic logic [12:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       w;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        w = 1'b0;
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                if (h == 4'd9) begin
                    h = 4'd0;
                    w = 1'b1;
                end else begin
                    h = h + 4'd1;
                end
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {w, h, t, o};
    endfunction

    // Increment request, next digit index, selected digit and blanking decision.
    always_comb begin
        inc_s = step | (run & (presc_r == PRESC_LAST));

        idx_nxt_s = idx_r;
        case (idx_r)
            2'd0:    idx_nxt_s = (scnt_r == SCAN_LAST) ? 2'd1 : 2'd0;
            2'd1:    idx_nxt_s = (scnt_r == SCAN_LAST) ? 2'd2 : 2'd1;
            2'd2:    idx_nxt_s = (scnt_r == SCAN_LAST) ? 2'd0 : 2'd2;
            default: idx_nxt_s = 2'd0;
        endcase

        sel_digit_s = 4'd0;
        an_nxt_s    = 3'b111;
        case (idx_nxt_s)
            2'd0: begin
                sel_digit_s = bcd_r[3:0];
                an_nxt_s    = 3'b110;
            end
            2'd1: begin
                sel_digit_s = bcd_r[7:4];
                an_nxt_s    = 3'b101;
            end
            2'd2: begin
                sel_digit_s = bcd_r[11:8];
                an_nxt_s    = 3'b011;
            end
            default: begin
                sel_digit_s = 4'd0;
                an_nxt_s    = 3'b111;
            end
        endcase

        if (BLANK_LZ != 0) begin
            blank_s = ((idx_nxt_s == 2'd2) && (bcd_r[11:8] == 4'd0)) ||
                      ((idx_nxt_s == 2'd1) && (bcd_r[11:4] == 8'd0));
        end else begin
            blank_s = 1'b0;
        end
    end

    // Run prescaler: counts only while running, cleared by load.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
        end else if (load) begin
            presc_r <= '0;
        end else if (run) begin
            presc_r <= (presc_r == PRESC_LAST) ? '0 : presc_r + PW'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // BCD count and rollover pulse; load wins over any increment request.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_r  <= 12'h000;
            wrap_r <= 1'b0;
        end else if (load) begin
            bcd_r  <= {sanitize_digit(load_val[11:8]),
                       sanitize_digit(load_val[7:4]),
                       sanitize_digit(load_val[3:0])};
            wrap_r <= 1'b0;
        end else if (inc_s) begin
            {wrap_r, bcd_r} <= bcd_inc(bcd_r);
        end else begin
            bcd_r  <= bcd_r;
            wrap_r <= 1'b0;
        end
    end

    // Free-running scan timer and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_r <= '0;
            idx_r  <= 2'd0;
        end else begin
            scnt_r <= (scnt_r == SCAN_LAST) ? '0 : scnt_r + SW'(1);
            idx_r  <= idx_nxt_s;
        end
    end

    // Display outputs follow the index on the same edge it changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_hex_r <= 4'h0;
            an_r        <= 3'b110;
            dp_r        <= 1'b1;
        end else begin
            digit_hex_r <= sel_digit_s;
            an_r        <= blank_s ? 3'b111 : an_nxt_s;
            dp_r        <= ((idx_nxt_s == 2'd0) && !run) ? 1'b0 : 1'b1;
        end
    end

    assign bcd_val   = bcd_r;
    assign wrap      = wrap_r;
    assign digit_hex = digit_hex_r;
    assign an        = an_r;
    assign dp        = dp_r;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: directed test-plan steps followed by
// random stimulus, all compared against an integer-count reference model.
module tb_bcd_scan_ctrl;

    localparam int TD = 4;
    localparam int SD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_val = 12'h000;
    logic [11:0] bcd_val;
    logic        wrap;
    logic [3:0]  digit_hex;
    logic [2:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_cnt;
    int          m_presc;
    int          m_k;
    logic        m_wrap;
    logic [3:0]  m_hex;
    logic [2:0]  m_an;
    logic        m_dp;

    bcd_scan_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .load(load),
        .load_val(load_val), .bcd_val(bcd_val), .wrap(wrap),
        .digit_hex(digit_hex), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic int clean_digit(input int d);
        return (d > 9) ? 0 : d;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        int old;
        int idx;
        int dig;
        bit tc;
        bit blank;
        if (reset) begin
            m_cnt = 0; m_presc = 0; m_k = 0; m_wrap = 1'b0;
            m_hex = 4'h0; m_an = 3'b110; m_dp = 1'b1;
        end else begin
            old = m_cnt;
            m_k++;
            tc = run && (m_presc == TD - 1);
            if (load) m_presc = 0;
            else if (run) m_presc = (m_presc + 1) % TD;
            if (load) begin
                m_cnt = clean_digit(int'(load_val[11:8])) * 100 +
                        clean_digit(int'(load_val[7:4])) * 10 +
                        clean_digit(int'(load_val[3:0]));
                m_wrap = 1'b0;
            end else if (step || tc) begin
                m_wrap = (m_cnt == 999);
                m_cnt = (m_cnt + 1) % 1000;
            end else begin
                m_wrap = 1'b0;
            end
            idx = (m_k / SD) % 3;
            dig = (idx == 0) ? old % 10 : (idx == 1) ? (old / 10) % 10 : old / 100;
            m_hex = 4'(dig);
            blank = (idx == 2 && old < 100) || (idx == 1 && old < 10);
            m_an = blank ? 3'b111 : ~(3'(1) << idx);
            m_dp = (idx == 0 && !run) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("bcd_val", bcd_val, to_bcd(m_cnt));
        chk("wrap", {11'd0, wrap}, {11'd0, m_wrap});
        chk("digit_hex", {8'd0, digit_hex}, {8'd0, m_hex});
        chk("an", {9'd0, an}, {9'd0, m_an});
        chk("dp", {11'd0, dp}, {11'd0, m_dp});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        ticks(2);
        chk("reset_bcd", bcd_val, 12'h000);
        chk("reset_an", {9'd0, an}, 12'h006);
        reset = 1'b0;

        // three step pulses four cycles apart
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            chk("step_count", bcd_val, 12'(i + 1));
            ticks(3);
        end

        // double carry 099 -> 100
        load_val = 12'h099; load = 1'b1; tick(); load = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        chk("dbl_carry", bcd_val, 12'h100);
        chk("dbl_carry_wrap", {11'd0, wrap}, 12'h000);
        ticks(2);

        // rollover 999 -> 000 with one-cycle wrap
        load_val = 12'h999; load = 1'b1; tick(); load = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        chk("rollover", bcd_val, 12'h000);
        chk("rollover_wrap", {11'd0, wrap}, 12'h001);
        tick();
        chk("wrap_drop", {11'd0, wrap}, 12'h000);

        // run for 20 cycles, pause 7, resume
        run = 1'b1; ticks(20);
        run = 1'b0; ticks(7);
        run = 1'b1; ticks(8);
        run = 1'b0; tick();

        // sanitising load, then load beating a same-cycle step
        load_val = 12'h1AF; load = 1'b1; tick(); load = 1'b0;
        chk("sanitise", bcd_val, 12'h100);
        load_val = 12'h050; load = 1'b1; step = 1'b1; tick(); load = 1'b0; step = 1'b0;
        chk("load_over_step", bcd_val, 12'h050);

        // leading-zero blanking and paused indicator on 007
        load_val = 12'h007; load = 1'b1; tick(); load = 1'b0;
        ticks(12);
        run = 1'b1; ticks(4);
        run = 1'b0;

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
            step = ($urandom_range(0, 3) == 0);
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 12'h999;
                1:       load_val = 12'h998;
                default: load_val = 12'($urandom);
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
